// File: rtl/nor_gate.sv
// nor_gate -- bitwise 2-input NOR leaf cell with a registered copy.
//
// Drives y = ~(a | b) combinationally. It also provides a one-cycle registered copy
// (y_q) and a registered flag (all_zero). The flag is set when both operands were
// all-zero on the previous cycle.
//
// Optional feature macro: NOR_GATE_STATS_EN
//   defined   : hi_cnt counts the edges on which all_zero loads a 1. The count
//               saturates at 2^CNT_W-1. cnt_clr clears the count, and a clear wins
//               over an increment in the same cycle.
//   undefined : hi_cnt is tied to 0 and cnt_clr is ignored.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset (clears y_q, all_zero, hi_cnt)
//   a, b      in   WIDTH  operands
//   y         out  WIDTH  ~(a | b), zero latency, not affected by reset
//   y_q       out  WIDTH  y delayed by one clk edge
//   all_zero  out  1      registered &y
//   hi_cnt    out  CNT_W  all-zero statistics counter
//   cnt_clr   in   1      synchronous counter clear
module nor_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             all_zero,
  output logic [CNT_W-1:0] hi_cnt,
  input  logic             cnt_clr
);

  logic all_zero_d;

  assign y = ~(a | b);

  // Both operands are zero exactly when every bit of the NOR result is high.
  assign all_zero_d = &y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q      <= '0;
      all_zero <= 1'b0;
    end else begin
      y_q      <= y;
      all_zero <= all_zero_d;
    end
  end

`ifdef NOR_GATE_STATS_EN
  logic [CNT_W-1:0] hi_cnt_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_cnt_r <= '0;
    end else if (cnt_clr) begin
      hi_cnt_r <= '0;
    end else if (all_zero_d && (hi_cnt_r != {CNT_W{1'b1}})) begin
      hi_cnt_r <= hi_cnt_r + CNT_W'(1);
    end
  end

  assign hi_cnt = hi_cnt_r;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign hi_cnt         = '0;
`endif

endmodule

// File: tb/tb_nor_gate.sv
module tb_nor_gate;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a1 = 1'b0, b1 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       clr1 = 1'b0;
  logic       cnt_clr = 1'b0;

  logic        y1, y1_q, az1;
  logic [15:0] cnt1;
  logic [7:0]  y8, y8_q;
  logic        az8;
  logic [3:0]  cnt8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nor_gate #(.WIDTH(1), .CNT_W(16)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .y(y1), .y_q(y1_q),
    .all_zero(az1), .hi_cnt(cnt1), .cnt_clr(clr1)
  );

  nor_gate #(.WIDTH(8), .CNT_W(4)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .y(y8), .y_q(y8_q),
    .all_zero(az8), .hi_cnt(cnt8), .cnt_clr(cnt_clr)
  );

  typedef struct {
    logic        y1q;
    logic        az1;
    logic [15:0] c1;
    logic [7:0]  y8q;
    logic        az8;
    logic [3:0]  c8;
  } exp_t;

  typedef struct {
    logic       a1, b1, ey1;
    logic [7:0] a8, b8, ey8;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;

  // reference counter model
  logic [15:0] m1 = '0;
  logic [3:0]  m8 = '0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one vector at the falling edge, check y at once, and queue the
  // registered values expected after the next rising edge.
  task automatic step(input logic ia1, input logic ib1, input logic ey1,
                      input logic [7:0] ia8, input logic [7:0] ib8, input logic [7:0] ey8,
                      input logic clr);
    exp_t e;
    logic z1, z8;
    @(negedge clk);
    a1 = ia1; b1 = ib1; a8 = ia8; b8 = ib8; cnt_clr = clr;
    #1;
    chk("y_w1", 16'(y1), 16'(ey1));
    chk("y_w8", 16'(y8), 16'(ey8));
    z1 = (ia1 == 1'b0) && (ib1 == 1'b0);
    z8 = (ia8 == 8'h00) && (ib8 == 8'h00);
`ifdef NOR_GATE_STATS_EN
    if (z1 && m1 != 16'hFFFF) m1 = m1 + 16'd1;
    if (clr) m8 = 4'd0;
    else if (z8 && m8 != 4'hF) m8 = m8 + 4'd1;
`endif
    e.y1q = ey1; e.az1 = z1; e.c1 = m1;
    e.y8q = ey8; e.az8 = z8; e.c8 = m8;
    sb_q.push_back(e);
  endtask

  // Monitor: registered outputs are presented every rising edge.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("y_q_w1",     16'(y1_q), 16'(mon_e.y1q));
      chk("all_zero_w1", 16'(az1), 16'(mon_e.az1));
      chk("hi_cnt_w1",  cnt1,      mon_e.c1);
      chk("y_q_w8",     16'(y8_q), 16'(mon_e.y8q));
      chk("all_zero_w8", 16'(az8), 16'(mon_e.az8));
      chk("hi_cnt_w8",  16'(cnt8), 16'(mon_e.c8));
    end
  end

  vec_t vecs[6] = '{
    '{1'b0, 1'b0, 1'b1, 8'hF0, 8'h0C, 8'h03},
    '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'hFF},
    '{1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h00},
    '{1'b1, 1'b1, 1'b0, 8'hA5, 8'h0A, 8'h50},
    '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'hFF},
    '{1'b1, 1'b1, 1'b0, 8'h12, 8'h40, 8'hAD}
  };

  initial begin
    // reset held from time 0; y must still be live
    #12;
    chk("rst_y_q_w8", 16'(y8_q), 16'h0000);
    chk("rst_all_zero_w8", 16'(az8), 16'h0000);
    chk("rst_hi_cnt_w8", 16'(cnt8), 16'h0000);
    chk("rst_y_w1", 16'(y1), 16'h0001);
    chk("rst_y_w8", 16'(y8), 16'h00FF);
    @(posedge clk); #2 rst_n = 1'b1;

    foreach (vecs[i])
      step(vecs[i].a1, vecs[i].b1, vecs[i].ey1, vecs[i].a8, vecs[i].b8, vecs[i].ey8, 1'b0);

    // hold all-zero long enough to saturate the 4-bit counter
    for (int i = 0; i < 20; i++)
      step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'hFF, 1'b0);
    @(posedge clk); #2;
`ifdef NOR_GATE_STATS_EN
    chk("sat_hi_cnt_w8", 16'(cnt8), 16'h000F);
`else
    chk("sat_hi_cnt_w8", 16'(cnt8), 16'h0000);
`endif

    // clear together with an incrementing condition, then resume counting
    step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'hFF, 1'b1);
    step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'hFF, 1'b0);

    // asynchronous reset mid-run with a=b=0
    @(posedge clk); #2 rst_n = 1'b0;
    m1 = '0; m8 = '0;
    #1;
    chk("midrst_y_q_w1", 16'(y1_q), 16'h0000);
    chk("midrst_all_zero_w1", 16'(az1), 16'h0000);
    chk("midrst_y_q_w8", 16'(y8_q), 16'h0000);
    chk("midrst_all_zero_w8", 16'(az8), 16'h0000);
    chk("midrst_hi_cnt_w1", cnt1, 16'h0000);
    chk("midrst_hi_cnt_w8", 16'(cnt8), 16'h0000);
    chk("midrst_y_w1", 16'(y1), 16'h0001);
    chk("midrst_y_w8", 16'(y8), 16'h00FF);
    @(posedge clk); #2 rst_n = 1'b1;

    // first edge after release samples normally
    step(1'b1, 1'b0, 1'b0, 8'hF0, 8'h0C, 8'h03, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'hFF, 1'b0);

    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(posedge clk);
    #3;
    if (sb_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
